// File: rtl/bec_pkg.sv
// Shared widths, core load_status codes and FSM encoding for the BEC host feeder.
package bec_pkg;

  localparam int WORD_W  = 32;
  localparam int OP_W    = 163;
  localparam int WORDS   = (OP_W + WORD_W - 1) / WORD_W;
  localparam int PACK_W  = WORDS * WORD_W;
  localparam int NUM_OPS = 6;
  localparam int CNT_W   = 3;
  localparam int KIDX_W  = 8;

  localparam logic [2:0] LS_A  = 3'b000;
  localparam logic [2:0] LS_B  = 3'b001;
  localparam logic [2:0] LS_C  = 3'b010;
  localparam logic [2:0] LS_D  = 3'b011;
  localparam logic [2:0] LS_d  = 3'b100;
  localparam logic [2:0] LS_W0 = 3'b101;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_KEY    = 4'd1,
    ST_REQ    = 4'd2,
    ST_OP_ASM = 4'd3,
    ST_COMMIT = 4'd4,
    ST_GO     = 4'd5,
    ST_RUN    = 4'd6,
    ST_UP_A   = 4'd7,
    ST_SEND_A = 4'd8,
    ST_UP_B   = 4'd9,
    ST_SEND_B = 4'd10
  } state_e;

  function automatic logic is_last_word(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(WORDS - 1);
  endfunction

endpackage

// File: rtl/bec_word_pack.sv
// Shift-in packer: WORDS host words, least-significant first, form one OP_W operand.
module bec_word_pack
  import bec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [WORD_W-1:0] word_in,
  output logic [OP_W-1:0]   data,
  output logic [CNT_W-1:0]  cnt,
  output logic              full
);

  logic [PACK_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign full = (cnt_q == CNT_W'(WORDS));
  assign cnt  = cnt_q;
  // New words enter at the top, so after WORDS shifts word 0 sits in the LSBs.
  assign data = sr_q[OP_W-1:0];

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clr) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift_en && !full) begin
      sr_d  = {word_in, sr_q[PACK_W-1:WORD_W]};
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bec_host_feeder.sv
// Host-side sequencer for the binary-Edwards-curve core: key/operand download,
// key-bit feeding during the ladder, and A/B result upload as host words.
//
// Handshakes: a word moves on in_* / out_* exactly when valid and ready are both
// high at a rising clk edge; valid never waits on ready, and out_data holds while
// out_valid is high without out_ready.
module bec_host_feeder
  import bec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              bec_load_data,
  output logic [2:0]        bec_load_status,
  output logic [OP_W-1:0]   bec_data_in,
  output logic              bec_enable,
  output logic              bec_ki,
  input  logic              bec_next_key,
  input  logic [3:0]        bec_status,
  input  logic              bec_done,
  input  logic [OP_W-1:0]   bec_data_out,
  output logic [3:0]        dbg_state
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [KIDX_W-1:0]   k_q, k_d;
  logic [OP_W-1:0]     hold_q, hold_d;
  logic [2:0]          ls_q, ls_d;
  logic                en_q, en_d;
  logic [PACK_W-1:0]   obuf_q, obuf_d;
  logic [CNT_W-1:0]    ocnt_q, ocnt_d;

  logic [OP_W-1:0]     key_data, stage_data;
  logic [CNT_W-1:0]    key_cnt, stage_cnt;
  logic                key_full, stage_full;
  logic                in_fire, out_fire;
  logic                key_clr, stage_clr;
  logic                unused_status;

  assign unused_status = ^{bec_status[3], bec_status[1:0]};

  assign in_ready  = ((state_q == ST_KEY) && !key_full) ||
                     ((state_q == ST_OP_ASM) && !stage_full);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state_q == ST_SEND_A) || (state_q == ST_SEND_B);
  assign out_fire  = out_valid && out_ready;
  assign out_data  = obuf_q[WORD_W-1:0];

  assign busy            = (state_q != ST_IDLE);
  assign bec_load_data   = (state_q == ST_REQ);
  assign bec_load_status = ls_q;
  assign bec_data_in     = hold_q;
  assign bec_enable      = en_q;
  assign dbg_state       = state_q;

  // Key register is frozen once KEY ends, so bec_ki only moves when k moves.
  assign bec_ki = ((state_q != ST_IDLE) && (state_q != ST_KEY)) ? key_data[k_q] : 1'b0;

  assign key_clr   = (state_q == ST_IDLE);
  assign stage_clr = (state_q == ST_REQ) || (state_q == ST_COMMIT);

  bec_word_pack u_key_pack (
    .clk      (clk),
    .rst      (rst),
    .clr      (key_clr),
    .shift_en (in_fire && (state_q == ST_KEY)),
    .word_in  (in_data),
    .data     (key_data),
    .cnt      (key_cnt),
    .full     (key_full)
  );

  bec_word_pack u_stage_pack (
    .clk      (clk),
    .rst      (rst),
    .clr      (stage_clr),
    .shift_en (in_fire && (state_q == ST_OP_ASM)),
    .word_in  (in_data),
    .data     (stage_data),
    .cnt      (stage_cnt),
    .full     (stage_full)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    hold_d  = hold_q;
    ls_d    = ls_q;
    en_d    = 1'b0;
    obuf_d  = obuf_q;
    ocnt_d  = ocnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_KEY;
      end
      ST_KEY: begin
        if (in_fire && is_last_word(key_cnt)) begin
          state_d = ST_REQ;
          k_d     = KIDX_W'(OP_W - 1);
        end
      end
      ST_REQ: begin
        if (bec_status[2]) begin
          state_d = ST_OP_ASM;
          n_d     = '0;
        end
      end
      ST_OP_ASM: begin
        if (in_fire && is_last_word(stage_cnt)) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        hold_d = stage_data;
        ls_d   = n_q;
        if (n_q < CNT_W'(NUM_OPS - 1)) begin
          n_d     = n_q + CNT_W'(1);
          state_d = ST_OP_ASM;
        end else begin
          state_d = ST_GO;
        end
      end
      ST_GO: begin
        // One idle cycle with operand 5 on the bus before the enable pulse lands.
        en_d    = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bec_next_key && (k_q != '0)) k_d = k_q - KIDX_W'(1);
        if (bec_done) begin
          state_d = ST_UP_A;
          ls_d    = LS_A;
        end
      end
      ST_UP_A: begin
        obuf_d  = {{(PACK_W - OP_W){1'b0}}, bec_data_out};
        ocnt_d  = '0;
        state_d = ST_SEND_A;
      end
      ST_UP_B: begin
        // The core drops out of upload on seeing LS_B, so capture here or never.
        obuf_d  = {{(PACK_W - OP_W){1'b0}}, bec_data_out};
        ocnt_d  = '0;
        ls_d    = LS_A;
        state_d = ST_SEND_B;
      end
      ST_SEND_A, ST_SEND_B: begin
        if (out_fire) begin
          obuf_d = obuf_q >> WORD_W;
          if (is_last_word(ocnt_q)) begin
            ocnt_d = '0;
            if (state_q == ST_SEND_A) begin
              state_d = ST_UP_B;
              ls_d    = LS_B;
            end else begin
              state_d = ST_IDLE;
              ls_d    = LS_A;
            end
          end else begin
            ocnt_d = ocnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      k_q     <= '0;
      hold_q  <= '0;
      ls_q    <= '0;
      en_q    <= 1'b0;
      obuf_q  <= '0;
      ocnt_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      hold_q  <= hold_d;
      ls_q    <= ls_d;
      en_q    <= en_d;
      obuf_q  <= obuf_d;
      ocnt_q  <= ocnt_d;
    end
  end

endmodule

// File: tb/tb_bec_host_feeder.sv
// Directed bench for bec_host_feeder with a small behavioural model of the core's bus.
module tb_bec_host_feeder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         busy;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic         bec_load_data;
  logic [2:0]   bec_load_status;
  logic [162:0] bec_data_in;
  logic         bec_enable;
  logic         bec_ki;
  logic         bec_next_key = 1'b0;
  logic [3:0]   bec_status = 4'b1000;
  logic         bec_done = 1'b0;
  logic [162:0] bec_data_out;
  logic [3:0]   dbg_state;

  logic [162:0] a_val, b_val;
  logic [31:0]  exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  int           din_changes = 0;
  int           ls_b_cycles = 0;
  int           en_cycles = 0;
  logic [162:0] prev_din = '0;
  logic [162:0] ub_seen = '0;

  int           din_snap, lsb_snap, en_snap;
  int           rx_n, cyc;
  bit           stalled, stable;
  logic [31:0]  held, got, exp_w;

  // Core model: result bus shows B only while the feeder selects B.
  assign bec_data_out = (bec_load_status == 3'b001) ? b_val : a_val;

  always #5 clk = ~clk;

  bec_host_feeder dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .busy            (busy),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .bec_load_data   (bec_load_data),
    .bec_load_status (bec_load_status),
    .bec_data_in     (bec_data_in),
    .bec_enable      (bec_enable),
    .bec_ki          (bec_ki),
    .bec_next_key    (bec_next_key),
    .bec_status      (bec_status),
    .bec_done        (bec_done),
    .bec_data_out    (bec_data_out),
    .dbg_state       (dbg_state)
  );

  always @(negedge clk) begin
    if (bec_data_in !== prev_din) din_changes <= din_changes + 1;
    prev_din <= bec_data_in;
    if (bec_load_status == 3'b001) begin
      ls_b_cycles <= ls_b_cycles + 1;
      ub_seen     <= bec_data_out;
    end
    if (bec_enable) en_cycles <= en_cycles + 1;
  end

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [162:0] op_val(input int n);
    logic [31:0] p;
    p = 32'h11111111 * 32'(n + 1);
    return {p[2:0], p, p, p, p, p};
  endfunction

  // Called just after a rising edge; returns 1 ns after the accepting edge (plus one idle cycle if gap).
  task automatic send_word(input logic [31:0] w, input bit gap);
    int waitc;
    waitc = 0;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check("in_ready", {191'b0, in_ready}, 192'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_op(input int n, input int nwords);
    logic [31:0] p;
    p = 32'h11111111 * 32'(n + 1);
    for (int i = 0; i < nwords; i++) send_word(p, 1'b1);
  endtask

  task automatic pulse_next_key();
    bec_next_key = 1'b1;
    @(posedge clk); #1;
    bec_next_key = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   {191'b0, busy},          192'd0);
    check({tag, "_irdy"},   {191'b0, in_ready},      192'd0);
    check({tag, "_ovld"},   {191'b0, out_valid},     192'd0);
    check({tag, "_odata"},  {160'b0, out_data},      192'd0);
    check({tag, "_ldata"},  {191'b0, bec_load_data}, 192'd0);
    check({tag, "_lstat"},  {189'b0, bec_load_status}, 192'd0);
    check({tag, "_din"},    {29'b0, bec_data_in},    192'd0);
    check({tag, "_en"},     {191'b0, bec_enable},    192'd0);
    check({tag, "_ki"},     {191'b0, bec_ki},        192'd0);
  endtask

  initial begin
    a_val = {3'h1, 32'h23456789, 32'hABCDEF01, 32'h13579BDF, 32'h2468ACE0, 32'hDEADBEEF};
    b_val = '1;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst0");
    @(posedge clk); #1;

    // Run 1: aborted by reset after 3 words of operand 2
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) send_word(32'hA5A5A5A5, 1'b0);
    send_word(32'h00000004, 1'b0);
    @(negedge clk);
    check("r1_ldata", {191'b0, bec_load_data}, 192'd1);
    check("r1_ki_msb", {191'b0, bec_ki}, 192'd1);
    @(posedge clk); #1;
    bec_status = 4'b0100;
    @(posedge clk); #1;
    send_op(0, 6);
    send_op(1, 6);
    send_op(2, 3);
    check("r1_din_op1", {29'b0, bec_data_in}, {29'b0, op_val(1)});
    check("r1_lstat_op1", {189'b0, bec_load_status}, 192'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    bec_status = 4'b1000;
    @(posedge clk); #1;

    // Run 2: key = 1, gapped operands, full ladder and upload
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_word(32'h00000001, 1'b0);
    for (int i = 0; i < 5; i++) send_word(32'h00000000, 1'b0);
    @(negedge clk);
    check("r2_ldata_7cyc", {191'b0, bec_load_data}, 192'd1);
    check("r2_busy", {191'b0, busy}, 192'd1);
    check("r2_ki_after_key", {191'b0, bec_ki}, 192'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("r2_ldata_hold", {191'b0, bec_load_data}, 192'd1);
    bec_status = 4'b0100;
    @(posedge clk); #1;
    check("r2_ldata_drop", {191'b0, bec_load_data}, 192'd0);
    din_snap = din_changes;
    for (int n = 0; n < 5; n++) begin
      send_op(n, 6);
      check($sformatf("r2_din_op%0d", n), {29'b0, bec_data_in}, {29'b0, op_val(n)});
      check($sformatf("r2_lstat_op%0d", n), {189'b0, bec_load_status}, 192'(n));
      check($sformatf("r2_ki_op%0d", n), {191'b0, bec_ki}, 192'd0);
    end
    en_snap = en_cycles;
    send_op(5, 6);
    @(negedge clk);
    check("r2_din_op5", {29'b0, bec_data_in}, {29'b0, op_val(5)});
    check("r2_din_op5_mask", {29'b0, bec_data_in}, {29'b0, 3'b110, {5{32'h66666666}}});
    check("r2_lstat_op5", {189'b0, bec_load_status}, 192'd5);
    check("r2_en_pre", {191'b0, bec_enable}, 192'd0);
    @(negedge clk);
    check("r2_en_pulse", {191'b0, bec_enable}, 192'd1);
    @(negedge clk);
    check("r2_en_after", {191'b0, bec_enable}, 192'd0);
    check("r2_en_count", 192'(en_cycles - en_snap), 192'd1);
    check("r2_din_updates", 192'(din_changes - din_snap), 192'd6);
    @(posedge clk); #1;

    // Ladder: start/in_valid while busy must be ignored
    bec_status = 4'b0010;
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hBAD0BAD0;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
    check("r2_run_irdy", {191'b0, in_ready}, 192'd0);
    check("r2_run_ldata", {191'b0, bec_load_data}, 192'd0);
    check("r2_run_ki0", {191'b0, bec_ki}, 192'd0);
    for (int i = 0; i < 161; i++) pulse_next_key();
    check("r2_ki_161", {191'b0, bec_ki}, 192'd0);
    pulse_next_key();
    check("r2_ki_162", {191'b0, bec_ki}, 192'd1);
    pulse_next_key();
    check("r2_ki_163", {191'b0, bec_ki}, 192'd1);

    // Upload
    exp_q = {32'hDEADBEEF, 32'h2468ACE0, 32'h13579BDF, 32'hABCDEF01, 32'h23456789, 32'h00000001,
             32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000007};
    lsb_snap = ls_b_cycles;
    bec_status = 4'b0001;
    bec_done = 1'b1;
    @(posedge clk); #1;
    check("r2_up_ovld0", {191'b0, out_valid}, 192'd0);
    check("r2_up_lstat_a", {189'b0, bec_load_status}, 192'd0);
    @(posedge clk); #1;
    check("r2_up_ovld1", {191'b0, out_valid}, 192'd1);
    bec_done = 1'b0;
    out_ready = 1'b1;
    rx_n = 0;
    cyc = 0;
    stalled = 1'b0;
    while (rx_n < 12 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (out_valid && out_ready) begin
        got = out_data;
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        check($sformatf("rx_word%0d", rx_n), {160'b0, got}, {160'b0, exp_w});
        rx_n++;
      end
      @(posedge clk); #1;
      if (rx_n == 2 && !stalled) begin
        stalled = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        held = out_data;
        stable = out_valid;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (out_data !== held || !out_valid) stable = 1'b0;
        end
        check("stall_stable", {191'b0, stable}, 192'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    end
    check("rx_count", 192'(rx_n), 192'd12);
    check("rx_leftover", 192'(exp_q.size()), 192'd0);
    check("ls_b_one_cycle", 192'(ls_b_cycles - lsb_snap), 192'd1);
    check("b_capture", {29'b0, ub_seen}, {29'b0, b_val});
    check("end_busy", {191'b0, busy}, 192'd0);
    check("end_ovld", {191'b0, out_valid}, 192'd0);
    check("end_lstat", {189'b0, bec_load_status}, 192'd0);
    out_ready = 1'b0;
    bec_status = 4'b1000;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
